cube_edge_sequencer: RTL

Upstream feeder for the line-drawing engine (LineCUBE). It holds the 8 projected vertices of a wireframe cube and walks a fixed 12-edge table. For each edge it presents endpoints x0/y0/x1/y1, pulses start, and waits for the engine's done before issuing the next edge. Vertices are double-buffered, so a CPU or transform stage can write new vertices while a frame is being drawn.

---
 rtl/cube_pkg.sv | 25 ++
 rtl/cube_vertex_bank.sv | 47 ++++
 rtl/cube_edge_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cube_pkg.sv
// rtl/cube_pkg.sv - shared widths, vertex type, FSM states and edge table
// for the cube edge sequencer.
package cube_pkg;

  localparam int XW     = 11;
  localparam int YW     = 10;
  localparam int N_VERT = 8;
  localparam int N_EDGE = 12;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } vertex_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

  // Edges 0-3 front face, 4-7 back face, 8-11 struts joining the faces.
  localparam logic [2:0] EDGE_A [N_EDGE] = '{3'd0, 3'd1, 3'd2, 3'd3,
                                             3'd4, 3'd5, 3'd6, 3'd7,
                                             3'd0, 3'd1, 3'd2, 3'd3};
  localparam logic [2:0] EDGE_B [N_EDGE] = '{3'd1, 3'd2, 3'd3, 3'd0,
                                             3'd5, 3'd6, 3'd7, 3'd4,
                                             3'd4, 3'd5, 3'd6, 3'd7};

endpackage

// File: rtl/cube_vertex_bank.sv
// rtl/cube_vertex_bank.sv - double-buffered vertex store: pending bank is
// written freely, active bank is snapshotted from it on copy_i.
module cube_vertex_bank
  import cube_pkg::*;
(
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          we_i,
  input  logic [2:0]    waddr_i,
  input  logic [XW-1:0] wx_i,
  input  logic [YW-1:0] wy_i,
  input  logic          copy_i,
  input  logic [2:0]    raddr_a_i,
  input  logic [2:0]    raddr_b_i,
  output logic [XW-1:0] ax_o,
  output logic [YW-1:0] ay_o,
  output logic [XW-1:0] bx_o,
  output logic [YW-1:0] by_o
);

  vertex_t pending_q [N_VERT];
  vertex_t active_q  [N_VERT];

  // The copy samples pending_q before this cycle's write lands, so a write
  // coincident with copy_i only reaches the pending bank.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < N_VERT; i++) begin
        pending_q[i] <= '0;
        active_q[i]  <= '0;
      end
    end else begin
      if (we_i) begin
        pending_q[waddr_i] <= '{x: wx_i, y: wy_i};
      end
      if (copy_i) begin
        active_q <= pending_q;
      end
    end
  end

  assign ax_o = active_q[raddr_a_i].x;
  assign ay_o = active_q[raddr_a_i].y;
  assign bx_o = active_q[raddr_b_i].x;
  assign by_o = active_q[raddr_b_i].y;

endmodule

// File: rtl/cube_edge_sequencer.sv
// rtl/cube_edge_sequencer.sv - walks the 12 cube edges, handing endpoints to
// the line engine one edge at a time with a start/done handshake.
module cube_edge_sequencer
  import cube_pkg::*;
(
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          vtx_we_i,
  input  logic [2:0]    vtx_addr_i,
  input  logic [XW-1:0] vtx_x_i,
  input  logic [YW-1:0] vtx_y_i,
  input  logic          go_i,
  input  logic          line_done_i,
  output logic [XW-1:0] x0_o,
  output logic [YW-1:0] y0_o,
  output logic [XW-1:0] x1_o,
  output logic [YW-1:0] y1_o,
  output logic          line_start_o,
  output logic [3:0]    edge_idx_o,
  output logic          busy_o,
  output logic          frame_done_o
);

  state_t        state_q, state_d;
  logic [3:0]    edge_idx_q, edge_idx_d;
  logic          busy_q, busy_d;
  logic          line_start_q, line_start_d;
  logic          frame_done_q, frame_done_d;
  logic          copy, load_ep;
  logic [2:0]    vtx_a, vtx_b;
  logic [XW-1:0] ax, bx, x0_q, x1_q;
  logic [YW-1:0] ay, by, y0_q, y1_q;

  assign vtx_a = EDGE_A[edge_idx_q];
  assign vtx_b = EDGE_B[edge_idx_q];

  cube_vertex_bank u_bank (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .we_i      (vtx_we_i),
    .waddr_i   (vtx_addr_i),
    .wx_i      (vtx_x_i),
    .wy_i      (vtx_y_i),
    .copy_i    (copy),
    .raddr_a_i (vtx_a),
    .raddr_b_i (vtx_b),
    .ax_o      (ax),
    .ay_o      (ay),
    .bx_o      (bx),
    .by_o      (by)
  );

  always_comb begin
    state_d      = state_q;
    edge_idx_d   = edge_idx_q;
    busy_d       = busy_q;
    line_start_d = 1'b0;
    frame_done_d = 1'b0;
    copy         = 1'b0;
    load_ep      = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_i) begin
          copy       = 1'b1;
          edge_idx_d = 4'd0;
          busy_d     = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        load_ep      = 1'b1;
        line_start_d = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        if (line_done_i) begin
          if (edge_idx_q == 4'(N_EDGE - 1)) begin
            state_d = FIN;
          end else begin
            edge_idx_d = edge_idx_q + 4'd1;
            state_d    = ISSUE;
          end
        end
      end
      FIN: begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        edge_idx_d   = 4'd0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      edge_idx_q   <= 4'd0;
      busy_q       <= 1'b0;
      line_start_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_idx_q   <= edge_idx_d;
      busy_q       <= busy_d;
      line_start_q <= line_start_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Endpoints load together with line_start and hold until the next ISSUE.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      x0_q <= '0;
      y0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
    end else if (load_ep) begin
      x0_q <= ax;
      y0_q <= ay;
      x1_q <= bx;
      y1_q <= by;
    end
  end

  assign x0_o         = x0_q;
  assign y0_o         = y0_q;
  assign x1_o         = x1_q;
  assign y1_o         = y1_q;
  assign line_start_o = line_start_q;
  assign edge_idx_o   = edge_idx_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule
